effect_frame_sequencer: RTL and testbench
=========================================

EFFECT_FRAME_SEQUENCER -- requirements
Module: effect_frame_sequencer

Interface
REQ-001 Parameter FRAME_LEN, default 1000, is the number of samples per frame (legal range 2..1024).
REQ-002 Parameter ADDR_W, default 10, is the sample buffer address width.
REQ-003 Parameter DONE_TIMEOUT, default 15, is the maximum number of cycles to wait for effect DONE.
REQ-004 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 FRAME_GO  in  1  one-cycle request to process one frame; sampled only in IDLE.
REQ-007 FRAME_BUSY  out  1  high from the cycle after FRAME_GO is accepted until FRAME_DONE.
REQ-008 FRAME_DONE  out  1  one-cycle pulse after the last output sample is written.
REQ-009 RD_ADDR  out  ADDR_W  input-buffer read address; data is valid one cycle later.
REQ-010 RD_DATA  in  16 signed  input-buffer read data.
REQ-011 FX_START  out  1  start pulse to the effect block.
REQ-012 FX_IN  out  16 signed  sample presented to the effect; held stable from FX_START until the sample completes.
REQ-013 FX_DONE  in  1  effect completion pulse.
REQ-014 FX_OUT  in  16 signed  effect result; valid in the cycle FX_DONE is high.
REQ-015 WR_EN  out  1  output-buffer write strobe, one cycle per sample.
REQ-016 WR_ADDR  out  ADDR_W  output-buffer write address.
REQ-017 WR_DATA  out  16 signed  output-buffer write data.
REQ-018 TIMEOUT_CNT  out  ADDR_W+1  number of samples in the current/last frame that timed out.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, LOAD, ISSUE, WAIT_DONE, WRITE, FINISH.
REQ-020 IDLE -> FETCH when FRAME_GO=1; the sample index and TIMEOUT_CNT are cleared to 0 on that transition.
REQ-021 FETCH: RD_ADDR = index; next state LOAD.
REQ-022 LOAD: RD_DATA is captured into FX_IN; next state ISSUE.
REQ-023 ISSUE: FX_START=1 for exactly this one cycle; wait counter cleared; next state WAIT_DONE.
REQ-024 FX_START SHALL never be high in two consecutive cycles or outside ISSUE.
REQ-025 WAIT_DONE: when FX_DONE=1, FX_OUT is captured into WR_DATA and the next state is WRITE.
REQ-026 WAIT_DONE: when DONE_TIMEOUT cycles elapse without FX_DONE, WR_DATA = FX_IN (bypass), TIMEOUT_CNT increments, and the next state is WRITE.
REQ-027 If FX_DONE arrives in the same cycle the timeout expires, FX_DONE wins and no timeout is counted.
REQ-028 FX_DONE outside WAIT_DONE SHALL be ignored.
REQ-029 WRITE: WR_EN=1 and WR_ADDR = index; if index = FRAME_LEN-1 the next state is FINISH, else index increments and the next state is FETCH.
REQ-030 FINISH: FRAME_DONE=1 for one cycle; next state IDLE.
REQ-031 FRAME_GO while not in IDLE SHALL be ignored.
REQ-032 Per-sample latency SHALL be 5 cycles plus the FX_DONE wait (FETCH, LOAD, ISSUE, >=1 WAIT_DONE, WRITE).
REQ-033 The index SHALL be ADDR_W bits and never exceed FRAME_LEN-1; TIMEOUT_CNT saturates at FRAME_LEN.
REQ-034 Data SHALL pass unmodified; the block performs no arithmetic on samples.

Reset
REQ-035 RESET SHALL asynchronously force IDLE, index=0, FX_START=0, WR_EN=0, FRAME_BUSY=0, FRAME_DONE=0, TIMEOUT_CNT=0, RD_ADDR=0, WR_ADDR=0, WR_DATA=0 and FX_IN=0.
REQ-036 RESET mid-frame SHALL abandon the frame with no further WR_EN or FRAME_DONE; a later FRAME_GO restarts at index 0.

Structure
REQ-037 The state enum and the 16-bit signed sample typedef SHALL live in the shared audio package (audio_pkg), alongside the default FRAME_LEN.
REQ-038 One sub-module, fx_wait_timer (a loadable down-counter with an expiry flag), is natural; everything else is a single FSM plus a datapath.

Verification
REQ-039 FRAME_LEN=4, input 0x1000,0x2000,0x3000,0x4000, responder that doubles and replies 1 cycle after START -> writes 0x2000,0x4000,0x6000,0x7FFF? no: 0x2000,0x4000,0x6000,0x8000 as given by the responder, addresses 0..3, one FRAME_DONE, TIMEOUT_CNT=0.
REQ-040 Responder that never asserts FX_DONE, FRAME_LEN=4 -> each sample is written as its input value after 15 wait cycles, and TIMEOUT_CNT=4.
REQ-041 FX_DONE asserted exactly on wait cycle 15 -> FX_OUT is written and TIMEOUT_CNT is unchanged.
REQ-042 RESET asserted during WAIT_DONE of sample 2 -> all outputs return to 0 immediately, with no WR_EN or FRAME_DONE afterwards; a new FRAME_GO processes from address 0.
REQ-043 FRAME_GO pulsed mid-frame and a spurious FX_DONE while in FETCH -> no effect on sequence, and exactly FRAME_LEN writes occur.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types: sample format, frame sequencer states and default frame size.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StIssue,
    StWaitDone,
    StWrite,
    StFinish
  } fsm_state_e;

  localparam int unsigned FrameLenDefault = 1000;

endpackage : audio_pkg

// File: rtl/fx_wait_timer.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
module fx_wait_timer #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            en_i,
  output logic            expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Load wins over counting; the count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule : fx_wait_timer

// File: rtl/effect_frame_sequencer.sv
// Streams one frame of samples through an external effect block, one sample at a time,
// substituting the dry sample when the effect fails to answer in time.
module effect_frame_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned FRAME_LEN    = FrameLenDefault,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DONE_TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                frame_go_i,
  output logic                frame_busy_o,
  output logic                frame_done_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic signed [15:0]  rd_data_i,
  output logic                fx_start_o,
  output logic signed [15:0]  fx_in_o,
  input  logic                fx_done_i,
  input  logic signed [15:0]  fx_out_i,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic signed [15:0]  wr_data_o,
  output logic [ADDR_W:0]     timeout_cnt_o
);

  localparam int unsigned TmrW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] TcntMax = (ADDR_W + 1)'(FRAME_LEN);

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  sample_t           fx_in_q, fx_in_d;
  sample_t           wr_data_q, wr_data_d;
  logic [ADDR_W:0]   tcnt_q, tcnt_d;
  logic              tmr_load, tmr_en, tmr_expired;

  // Expiry lands on the DONE_TIMEOUT-th WAIT_DONE cycle, so load one less than the limit.
  fx_wait_timer #(
    .CntW (TmrW)
  ) u_fx_wait_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (TmrW'(DONE_TIMEOUT - 1)),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  // Next-state and datapath update; FX_DONE is only looked at in WAIT_DONE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fx_in_d   = fx_in_q;
    wr_data_d = wr_data_q;
    tcnt_d    = tcnt_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_go_i) begin
          idx_d   = '0;
          tcnt_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        fx_in_d = rd_data_i;
        state_d = StIssue;
      end
      StIssue: begin
        tmr_load = 1'b1;
        state_d  = StWaitDone;
      end
      StWaitDone: begin
        tmr_en = 1'b1;
        // A reply arriving on the expiry cycle still counts as a reply.
        if (fx_done_i) begin
          wr_data_d = fx_out_i;
          state_d   = StWrite;
        end else if (tmr_expired) begin
          wr_data_d = fx_in_q;
          if (tcnt_q < TcntMax) begin
            tcnt_d = tcnt_q + (ADDR_W + 1)'(1);
          end
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (idx_q == LastIdx) begin
          state_d = StFinish;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      fx_in_q   <= '0;
      wr_data_q <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fx_in_q   <= fx_in_d;
      wr_data_q <= wr_data_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign frame_busy_o  = (state_q != StIdle);
  assign frame_done_o  = (state_q == StFinish);
  assign fx_start_o    = (state_q == StIssue);
  assign wr_en_o       = (state_q == StWrite);
  assign rd_addr_o     = idx_q;
  assign wr_addr_o     = idx_q;
  assign fx_in_o       = fx_in_q;
  assign wr_data_o     = wr_data_q;
  assign timeout_cnt_o = tcnt_q;

endmodule : effect_frame_sequencer

// File: tb/tb_effect_frame_sequencer.sv
// Directed bench for effect_frame_sequencer with a 4-sample frame and a configurable responder.
module tb_effect_frame_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               frame_go = 1'b0;
  logic               frame_busy, frame_done;
  logic [9:0]         rd_addr;
  logic signed [15:0] rd_data = '0;
  logic               fx_start;
  logic signed [15:0] fx_in;
  logic               fx_done;
  logic signed [15:0] fx_out;
  logic               wr_en;
  logic [9:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic [10:0]        timeout_cnt;

  effect_frame_sequencer #(
    .FRAME_LEN    (4),
    .ADDR_W       (10),
    .DONE_TIMEOUT (15)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .frame_go_i    (frame_go),
    .frame_busy_o  (frame_busy),
    .frame_done_o  (frame_done),
    .rd_addr_o     (rd_addr),
    .rd_data_i     (rd_data),
    .fx_start_o    (fx_start),
    .fx_in_o       (fx_in),
    .fx_done_i     (fx_done),
    .fx_out_i      (fx_out),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .timeout_cnt_o (timeout_cnt)
  );

  always #5 clk = ~clk;

  // Input buffer with one-cycle read latency.
  logic signed [15:0] mem [0:3];
  initial begin
    mem[0] = 16'sh1000;
    mem[1] = 16'sh2000;
    mem[2] = 16'sh3000;
    mem[3] = 16'sh4000;
  end
  always @(posedge clk) rd_data <= mem[rd_addr[1:0]];

  // Responder: replies with the doubled sample rdelay cycles after START (0 = never).
  int   rdelay = 1;
  int   rcnt = 0;
  logic spur = 1'b0;
  always @(posedge clk) begin
    if (fx_start && rdelay != 0) rcnt <= rdelay;
    else if (rcnt != 0) rcnt <= rcnt - 1;
  end
  assign fx_done = (rcnt == 1) || spur;
  assign fx_out  = fx_in <<< 1;

  // Write / done / start monitor.
  int         nwr = 0;
  int         ndone = 0;
  int         nstart_bad = 0;
  logic       start_q = 1'b0;
  logic [9:0] wlog_addr [0:63];
  logic [15:0] wlog_data [0:63];
  always @(posedge clk) begin
    if (wr_en) begin
      if (nwr < 64) begin
        wlog_addr[nwr] <= wr_addr;
        wlog_data[nwr] <= wr_data;
      end
      nwr <= nwr + 1;
    end
    if (frame_done) ndone <= ndone + 1;
    if (fx_start && start_q) nstart_bad <= nstart_bad + 1;
    start_q <= fx_start;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from a negedge; optional extra FRAME_GO and spurious FX_DONE cycles.
  task automatic run_frame(input int go_again_at, input int spur_at, output int cyc,
                           output logic busy1);
    cyc = 0;
    busy1 = 1'b0;
    frame_go = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = frame_busy;
      frame_go = (cyc == go_again_at);
      spur = (cyc == spur_at);
    end while (!frame_done && cyc < 400);
    frame_go = 1'b0;
    spur = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_writes(input string tag, input int base, input logic [15:0] d0,
                            input logic [15:0] d1, input logic [15:0] d2,
                            input logic [15:0] d3);
    logic [15:0] exp_d [0:3];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_addr"}, 32'(wlog_addr[base + i]), 32'(i));
      chk({tag, "_data"}, 32'(wlog_data[base + i]), 32'(exp_d[i]));
    end
  endtask

  int   cyc;
  logic busy1;
  int   wbase, dbase;

  initial begin
    // Reset state.
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(frame_busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_start", 32'(fx_start), 0);
    chk("rst_wren", 32'(wr_en), 0);
    chk("rst_tcnt", 32'(timeout_cnt), 0);
    chk("rst_rdaddr", 32'(rd_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    // Responder doubles after 1 cycle.
    rdelay = 1; wbase = nwr; dbase = ndone;
    run_frame(0, 0, cyc, busy1);
    chk("t1_busy_first", 32'(busy1), 1);
    chk("t1_cycles", 32'(cyc), 21);
    chk("t1_nwr", 32'(nwr - wbase), 4);
    chk("t1_ndone", 32'(ndone - dbase), 1);
    chk("t1_tcnt", 32'(timeout_cnt), 0);
    chk("t1_busy_after", 32'(frame_busy), 0);
    chk_writes("t1", wbase, 16'h2000, 16'h4000, 16'h6000, 16'h8000);

    // Responder never answers: every sample bypassed.
    rdelay = 0; wbase = nwr; dbase = ndone;
    run_frame(0, 0, cyc, busy1);
    chk("t2_cycles", 32'(cyc), 77);
    chk("t2_nwr", 32'(nwr - wbase), 4);
    chk("t2_ndone", 32'(ndone - dbase), 1);
    chk("t2_tcnt", 32'(timeout_cnt), 4);
    chk_writes("t2", wbase, 16'h1000, 16'h2000, 16'h3000, 16'h4000);

    // Reply exactly on the 15th wait cycle: reply wins.
    rdelay = 15; wbase = nwr; dbase = ndone;
    run_frame(0, 0, cyc, busy1);
    chk("t3_cycles", 32'(cyc), 77);
    chk("t3_nwr", 32'(nwr - wbase), 4);
    chk("t3_tcnt", 32'(timeout_cnt), 0);
    chk_writes("t3", wbase, 16'h2000, 16'h4000, 16'h6000, 16'h8000);

    // Reset during WAIT_DONE of sample 2 (cycle 45 of a no-reply frame).
    rdelay = 0; wbase = nwr; dbase = ndone;
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
    repeat (44) @(negedge clk);
    chk("t4_pre_fxin", 32'(fx_in), 32'h3000);
    rst = 1'b1;
    #1;
    chk("t4_busy", 32'(frame_busy), 0);
    chk("t4_done", 32'(frame_done), 0);
    chk("t4_start", 32'(fx_start), 0);
    chk("t4_wren", 32'(wr_en), 0);
    chk("t4_tcnt", 32'(timeout_cnt), 0);
    chk("t4_rdaddr", 32'(rd_addr), 0);
    chk("t4_wraddr", 32'(wr_addr), 0);
    chk("t4_wrdata", 32'(wr_data), 0);
    chk("t4_fxin", 32'(fx_in), 0);
    chk("t4_nwr_pre", 32'(nwr - wbase), 2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t4_nwr_post", 32'(nwr - wbase), 2);
    chk("t4_ndone_post", 32'(ndone - dbase), 0);
    rdelay = 1; wbase = nwr; dbase = ndone;
    run_frame(0, 0, cyc, busy1);
    chk("t4_restart_cycles", 32'(cyc), 21);
    chk("t4_restart_nwr", 32'(nwr - wbase), 4);
    chk("t4_restart_ndone", 32'(ndone - dbase), 1);
    chk_writes("t4r", wbase, 16'h2000, 16'h4000, 16'h6000, 16'h8000);

    // FRAME_GO mid-frame and spurious FX_DONE during FETCH of sample 1.
    rdelay = 1; wbase = nwr; dbase = ndone;
    run_frame(3, 6, cyc, busy1);
    chk("t5_cycles", 32'(cyc), 21);
    chk("t5_nwr", 32'(nwr - wbase), 4);
    chk("t5_ndone", 32'(ndone - dbase), 1);
    chk("t5_tcnt", 32'(timeout_cnt), 0);
    chk_writes("t5", wbase, 16'h2000, 16'h4000, 16'h6000, 16'h8000);
    repeat (10) @(negedge clk);
    chk("t5_idle_nwr", 32'(nwr - wbase), 4);

    chk("start_back_to_back", 32'(nstart_bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_effect_frame_sequencer
